// File: rtl/alu_reserve_station_if.sv
// ----------------------------------------------------------------------------
// alu_rs_pkg / alu_rs_if : entry types and dispatch/CDB/issue bundle for the
// ALU reservation station.   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package alu_rs_pkg;
  localparam int RS_IDX_W  = 2;
  localparam int ROB_IDX_W = 4;

  typedef logic [RS_IDX_W-1:0]  rs_index_t;
  typedef logic [ROB_IDX_W-1:0] rob_index_t;

  typedef struct packed {
    logic                   busy;
    logic [3:0]             alu_op;
    rob_index_t             reorder;
    rs_index_t              index;
    logic [1:0]             operand_ready;
    rob_index_t [1:0]       operand_addr;
    logic [1:0][31:0]       operand;
  } reserve_station_t;
endpackage

interface alu_rs_if #(
  parameter int CDB_WIDTH = 2
);
  import alu_rs_pkg::*;

  logic                        flush;
  logic                        taken;
  reserve_station_t            rs_in;
  logic                        ready;
  rs_index_t                   index;
  logic [CDB_WIDTH-1:0]        cdb_valid;
  rob_index_t [CDB_WIDTH-1:0]  cdb_reorder;
  logic [CDB_WIDTH-1:0][31:0]  cdb_data;
  logic                        issue_valid;
  reserve_station_t            issue_entry;
  logic                        issue_ack;

  modport master (
    output flush, taken, rs_in, cdb_valid, cdb_reorder, cdb_data, issue_ack,
    input  ready, index, issue_valid, issue_entry
  );

  modport slave (
    input  flush, taken, rs_in, cdb_valid, cdb_reorder, cdb_data, issue_ack,
    output ready, index, issue_valid, issue_entry
  );
endinterface

`default_nettype wire

// File: rtl/alu_reserve_station.sv
// ----------------------------------------------------------------------------
// alu_reserve_station : ALU reservation station with CDB wakeup and oldest-
// ready issue. Optional RS_CDB_BYPASS_EN allows issue in the broadcast cycle.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_reserve_station
  import alu_rs_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int CDB_WIDTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  alu_rs_if.slave  rs
);

  reserve_station_t        entry_q [DEPTH];
  reserve_station_t        entry_d [DEPTH];
  logic [DEPTH-1:0]        busy_q, busy_d;
  logic [DEPTH-1:0]        age_q [DEPTH];
  logic [DEPTH-1:0]        age_d [DEPTH];

  reserve_station_t        woken [DEPTH];
  reserve_station_t        view  [DEPTH];
  reserve_station_t        in_woken;
  logic [DEPTH-1:0]        cand;
  rs_index_t               sel_idx;
  logic                    any_cand;
  logic                    older;

  // Lowest CDB port wins when several match the same operand.
  function automatic reserve_station_t wake(
    input reserve_station_t            e,
    input logic [CDB_WIDTH-1:0]        v,
    input rob_index_t [CDB_WIDTH-1:0]  tag,
    input logic [CDB_WIDTH-1:0][31:0]  d
  );
    reserve_station_t r;
    r = e;
    for (int k = 0; k < 2; k++) begin
      if (!e.operand_ready[k]) begin
        for (int p = CDB_WIDTH - 1; p >= 0; p--) begin
          if (v[p] && (tag[p] == e.operand_addr[k])) begin
            r.operand[k]       = d[p];
            r.operand_ready[k] = 1'b1;
          end
        end
      end
    end
    return r;
  endfunction

  assign in_woken = wake(rs.rs_in, rs.cdb_valid, rs.cdb_reorder, rs.cdb_data);

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    assign woken[g] = wake(entry_q[g], rs.cdb_valid, rs.cdb_reorder, rs.cdb_data);
`ifdef RS_CDB_BYPASS_EN
    assign view[g]  = woken[g];
`else
    assign view[g]  = entry_q[g];
`endif
    assign cand[g]  = busy_q[g] & (&view[g].operand_ready);
  end

  always_comb begin
    rs.ready = ~(&busy_q);
    rs.index = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) rs.index = rs_index_t'(i);
    end
  end

  // The age matrix gives a total order over busy entries, so exactly one
  // candidate is older than every other candidate.
  always_comb begin
    sel_idx = '0;
    older   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      older = 1'b1;
      for (int j = 0; j < DEPTH; j++) begin
        if ((j != i) && cand[j] && !age_q[i][j]) older = 1'b0;
      end
      if (cand[i] && older) sel_idx = rs_index_t'(i);
    end
  end

  assign any_cand       = |cand;
  assign rs.issue_valid = any_cand;
  assign rs.issue_entry = any_cand ? view[sel_idx] : '0;

  always_comb begin
    entry_d = entry_q;
    busy_d  = busy_q;
    age_d   = age_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (busy_q[i]) entry_d[i] = woken[i];
    end
    if (any_cand && rs.issue_ack) busy_d[sel_idx] = 1'b0;
    if (rs.taken) begin
      entry_d[rs.rs_in.index]      = in_woken;
      entry_d[rs.rs_in.index].busy = 1'b1;
      busy_d[rs.rs_in.index]       = 1'b1;
      age_d[rs.rs_in.index]        = '0;
      for (int i = 0; i < DEPTH; i++) begin
        age_d[i][rs.rs_in.index] = busy_q[i];
      end
    end
    if (rs.flush) begin
      busy_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_d[i] = '0;
        age_d[i]   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
        age_q[i]   <= '0;
      end
    end else begin
      busy_q <= busy_d;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
        age_q[i]   <= age_d[i];
      end
    end
  end

`ifndef SYNTHESIS
  a_no_dispatch_when_full: assert property (@(posedge clk) disable iff (rst)
    rs.taken |-> rs.ready);
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_reserve_station.sv
// ----------------------------------------------------------------------------
// tb_alu_reserve_station : directed bench with a slot/sequence-number model.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_alu_reserve_station;
  import alu_rs_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_rs_if #(.CDB_WIDTH(2)) bus ();

  alu_reserve_station #(.DEPTH(DEPTH), .CDB_WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .rs  (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit               v;
    int               seq;
    reserve_station_t e;
  } slot_t;

  slot_t m [DEPTH];
  int    seqc;

  task automatic chk1(input string n, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  task automatic chki(input string n, input rs_index_t a, input rs_index_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  task automatic chk32(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  task automatic chke(input string n, input reserve_station_t a, input reserve_station_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  function automatic reserve_station_t mk(input rs_index_t idx, input rob_index_t rob,
      input rob_index_t a0, input bit r0, input logic [31:0] d0,
      input rob_index_t a1, input bit r1, input logic [31:0] d1);
    reserve_station_t e;
    e = '0;
    e.alu_op           = 4'h3;
    e.reorder          = rob;
    e.index            = idx;
    e.operand_addr[0]  = a0;
    e.operand_addr[1]  = a1;
    e.operand_ready[0] = r0;
    e.operand_ready[1] = r1;
    e.operand[0]       = r0 ? d0 : 32'h0;
    e.operand[1]       = r1 ? d1 : 32'h0;
    return e;
  endfunction

  function automatic reserve_station_t mwake(input reserve_station_t e);
    reserve_station_t r;
    r = e;
    for (int k = 0; k < 2; k++) begin
      if (!e.operand_ready[k]) begin
        for (int p = 0; p < 2; p++) begin
          if (bus.cdb_valid[p] && bus.cdb_reorder[p] == e.operand_addr[k]) begin
            r.operand[k]       = bus.cdb_data[p];
            r.operand_ready[k] = 1'b1;
            break;
          end
        end
      end
    end
    return r;
  endfunction

  function automatic reserve_station_t mview(input int i);
`ifdef RS_CDB_BYPASS_EN
    return mwake(m[i].e);
`else
    return m[i].e;
`endif
  endfunction

  function automatic int msel();
    int best;
    reserve_station_t w;
    best = -1;
    for (int i = 0; i < DEPTH; i++) begin
      w = mview(i);
      if (m[i].v && w.operand_ready == 2'b11 && (best < 0 || m[i].seq < m[best].seq))
        best = i;
    end
    return best;
  endfunction

  function automatic rs_index_t mfree();
    rs_index_t r;
    r = '0;
    for (int i = DEPTH - 1; i >= 0; i--) if (!m[i].v) r = rs_index_t'(i);
    return r;
  endfunction

  function automatic logic mready();
    logic r;
    r = 1'b0;
    for (int i = 0; i < DEPTH; i++) if (!m[i].v) r = 1'b1;
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m[i].v = 1'b0;
      m[i].e = '0;
      m[i].seq = 0;
    end
    seqc = 0;
  endtask

  task automatic model_step();
    int s;
    rs_index_t w;
    s = msel();
    if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) m[i].v = 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) if (m[i].v) m[i].e = mwake(m[i].e);
      if (s >= 0 && bus.issue_ack) m[s].v = 1'b0;
      if (bus.taken) begin
        w = bus.rs_in.index;
        m[w].v      = 1'b1;
        m[w].seq    = seqc;
        seqc++;
        m[w].e      = mwake(bus.rs_in);
        m[w].e.busy = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    int s;
    s = msel();
    chk1("model_ready", bus.ready, mready());
    chki("model_index", bus.index, mfree());
    chk1("model_issue_valid", bus.issue_valid, s >= 0);
    if (s >= 0) chke("model_issue_entry", bus.issue_entry, mview(s));
  endtask

  task automatic clear_inputs();
    bus.flush       = 1'b0;
    bus.taken       = 1'b0;
    bus.rs_in       = '0;
    bus.cdb_valid   = '0;
    bus.cdb_reorder = '0;
    bus.cdb_data    = '0;
    bus.issue_ack   = 1'b0;
  endtask

  // One clock: compare at the falling edge, advance the model, then the edge.
  task automatic cyc();
    @(negedge clk);
    compare_all();
    model_step();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic dispatch(input rob_index_t rob,
      input rob_index_t a0, input bit r0, input logic [31:0] d0,
      input rob_index_t a1, input bit r1, input logic [31:0] d1);
    bus.taken = 1'b1;
    bus.rs_in = mk(mfree(), rob, a0, r0, d0, a1, r1, d1);
  endtask

  task automatic cdb(input int p, input rob_index_t tag, input logic [31:0] d);
    bus.cdb_valid[p]   = 1'b1;
    bus.cdb_reorder[p] = tag;
    bus.cdb_data[p]    = d;
  endtask

  reserve_station_t x;

  initial begin
    rst = 1'b1;
    clear_inputs();
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk1("reset_ready", bus.ready, 1'b1);
    chki("reset_index", bus.index, 2'd0);
    chk1("reset_issue_valid", bus.issue_valid, 1'b0);
    chke("reset_issue_entry", bus.issue_entry, '0);

    // Reset in the middle of operation
    dispatch(4'd1, 4'd9, 1'b0, 32'h0, 4'd0, 1'b1, 32'h11);
    cyc();
    dispatch(4'd2, 4'd9, 1'b0, 32'h0, 4'd0, 1'b1, 32'h22);
    cyc();
    chk1("two_busy_ready", bus.ready, 1'b1);
    chki("two_busy_index", bus.index, 2'd2);
    #2 rst = 1'b1;
    model_clear();
    #1;
    chk1("async_rst_ready", bus.ready, 1'b1);
    chki("async_rst_index", bus.index, 2'd0);
    chk1("async_rst_issue_valid", bus.issue_valid, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    dispatch(4'd3, 4'd0, 1'b1, 32'h10, 4'd0, 1'b1, 32'h20);
    chki("after_rst_slot", bus.rs_in.index, 2'd0);
    cyc();
    x = mk(2'd0, 4'd3, 4'd0, 1'b1, 32'h10, 4'd0, 1'b1, 32'h20);
    x.busy = 1'b1;
    chk1("after_rst_issue_valid", bus.issue_valid, 1'b1);
    chke("after_rst_issue_entry", bus.issue_entry, x);
    bus.issue_ack = 1'b1;
    cyc();

    // Oldest-first selection
    dispatch(4'd8, 4'd5, 1'b0, 32'h0, 4'd0, 1'b1, 32'h2);
    cyc();
    dispatch(4'd9, 4'd0, 1'b1, 32'h7, 4'd0, 1'b1, 32'h8);
    cyc();
    chk1("oldest_b_valid", bus.issue_valid, 1'b1);
    chki("oldest_b_slot", bus.issue_entry.index, 2'd1);
    bus.issue_ack = 1'b1;
    cyc();
    cdb(0, 4'd5, 32'h1234);
    #1;
`ifdef RS_CDB_BYPASS_EN
    chk1("bypass_a_valid", bus.issue_valid, 1'b1);
    chk32("bypass_a_op0", bus.issue_entry.operand[0], 32'h1234);
    bus.issue_ack = 1'b1;
    cyc();
`else
    chk1("wake_not_same_cycle", bus.issue_valid, 1'b0);
    cyc();
    chk1("wake_a_valid", bus.issue_valid, 1'b1);
    chk32("wake_a_op0", bus.issue_entry.operand[0], 32'h1234);
    bus.issue_ack = 1'b1;
    cyc();
`endif
    chk1("oldest_drained", bus.issue_valid, 1'b0);

    // Dispatch coincident with a broadcast, then backpressure
    dispatch(4'd6, 4'd0, 1'b1, 32'h5, 4'd7, 1'b0, 32'h0);
    cdb(1, 4'd7, 32'hDEAD);
    cyc();
    x = mk(2'd0, 4'd6, 4'd0, 1'b1, 32'h5, 4'd7, 1'b1, 32'hDEAD);
    x.busy = 1'b1;
    chk1("collide_valid", bus.issue_valid, 1'b1);
    chk32("collide_op1", bus.issue_entry.operand[1], 32'hDEAD);
    chke("bp_entry_0", bus.issue_entry, x);
    dispatch(4'd10, 4'd0, 1'b1, 32'hA, 4'd0, 1'b1, 32'hB);
    cyc();
    chke("bp_entry_1", bus.issue_entry, x);
    cyc();
    chke("bp_entry_2", bus.issue_entry, x);
    bus.issue_ack = 1'b1;
    cyc();
    chk1("bp_second_valid", bus.issue_valid, 1'b1);
    chki("bp_second_slot", bus.issue_entry.index, 2'd1);
    bus.issue_ack = 1'b1;
    cyc();
    chk1("bp_empty_valid", bus.issue_valid, 1'b0);
    chk1("bp_empty_ready", bus.ready, 1'b1);

    // Full boundary
    for (int i = 0; i < DEPTH; i++) begin
      dispatch(rob_index_t'(i + 1), rob_index_t'(i + 1), 1'b0, 32'h0, 4'd0, 1'b1, 32'h1);
      cyc();
    end
    chk1("full_ready", bus.ready, 1'b0);
    chki("full_index", bus.index, 2'd0);
    cdb(0, 4'd3, 32'h33);
    cyc();
    chk1("full_slot2_valid", bus.issue_valid, 1'b1);
    chki("full_slot2_sel", bus.issue_entry.index, 2'd2);
    bus.issue_ack = 1'b1;
    #1;
    chk1("full_ready_during_ack", bus.ready, 1'b0);
    cyc();
    chk1("freed_ready", bus.ready, 1'b1);
    chki("freed_index", bus.index, 2'd2);

    // Flush beats dispatch, ack and wakeup in the same cycle
    cdb(0, 4'd1, 32'h11);
    cyc();
    chk1("pre_flush_valid", bus.issue_valid, 1'b1);
    dispatch(4'd12, 4'd0, 1'b1, 32'h1, 4'd0, 1'b1, 32'h2);
    bus.flush     = 1'b1;
    bus.issue_ack = 1'b1;
    cdb(1, 4'd2, 32'h22);
    cyc();
    chk1("flush_ready", bus.ready, 1'b1);
    chki("flush_index", bus.index, 2'd0);
    chk1("flush_issue_valid", bus.issue_valid, 1'b0);
    cyc();
    chk1("flush_idle_valid", bus.issue_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_reserve_station.md
Name: alu_reserve_station

Overview:
- ALU reservation station sitting directly downstream of the dispatcher.
- Accepts one dispatched instruction per cycle into a free slot. The dispatcher is told which slot through ready/index.
- Snoops the common data bus (CDB) to wake up pending operands.
- Issues the oldest instruction whose operands are both ready to the ALU, using a valid/ack handshake.

Parameters:
- DEPTH, 4, number of entries (power of two, at least 2).
- CDB_WIDTH, 2, number of CDB broadcast ports snooped per cycle.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  pipeline flush (mispredict or exception); clears all entries.
- taken  in  1  dispatcher writes rs_in this cycle.
- rs_in  in  reserve_station_t  entry to write; written to slot rs_in.index.
- ready  out  1  at least one free slot exists.
- index  out  rs_index_t  lowest-numbered free slot.
- cdb_valid  in  CDB_WIDTH  broadcast valid per port.
- cdb_reorder  in  CDB_WIDTH x rob_index_t  producing ROB tag per port.
- cdb_data  in  CDB_WIDTH x 32  result value per port.
- issue_valid  out  1  issue_entry holds a fully-ready instruction.
- issue_entry  out  reserve_station_t  selected entry, operands filled.
- issue_ack  in  1  ALU accepts issue_entry this cycle.

Behaviour:
- State per entry:
  - the reserve_station_t fields;
  - a busy bit;
  - a DEPTH x DEPTH age matrix; age[i][j]=1 means entry i is older than entry j.
- Reset (asynchronous) and flush (synchronous, at the clock edge):
  - all busy bits cleared, age matrix cleared.
  - Outputs after reset: ready=1, index=0, issue_valid=0, issue_entry='0.
- Flush priority: flush overrides taken, CDB wakeup and issue_ack in the same cycle. Nothing is written and nothing survives.
- ready and index:
  - combinational from registered busy bits only.
  - A slot freed by issue_ack this cycle becomes visible next cycle.
  - When all slots are busy: ready=0, index=0.
- Allocation, on taken=1:
  - slot rs_in.index gets rs_in, and busy is set.
  - Its age row is set to 0 and its age column to 1 for every currently busy entry, so the new entry is youngest.
  - taken=1 while ready=0 is illegal; flag it with a simulation assertion.
  - rs_in.busy is ignored; taken is authoritative.
- Wakeup, per busy entry and per operand k with operand_ready[k]=0:
  - if any cdb_valid[p] has cdb_reorder[p]==operand_addr[k], capture cdb_data[p] and set operand_ready[k]=1 at the clock edge.
  - If multiple ports match, the lowest p wins; the ROB guarantees this cannot happen.
- Write/CDB collision: an entry written this cycle also snoops the CDB in the same cycle. A broadcast coincident with dispatch must not be lost.
- Selection:
  - candidate = busy and both operand_ready bits set.
  - Select the candidate older than all other candidates.
  - issue_valid = any candidate.
  - issue_entry = the selected entry, combinational from registered state.
- Issue handshake:
  - on issue_valid & issue_ack, the selected entry's busy bit clears at the edge.
  - issue_entry holds stable while issue_valid=1 and issue_ack=0, unless a strictly older entry becomes ready. In that case it is replaced; the ALU treats valid/ack per cycle.
- Simultaneous taken and issue_ack: legal. The two slots are always distinct, because index is never the slot being issued (that slot is busy).
- Throughput: one allocation plus one issue per cycle.
- Latency: dispatch with ready operands reaches issue_valid the next cycle. A CDB wakeup is followed by issue_valid the next cycle.

Optional Feature:
- RS_CDB_BYPASS_EN
- Defined:
  - the candidate condition also counts an operand ready if a CDB port matches it in the current cycle.
  - issue_entry muxes in that cdb_data, so an entry can issue in the same cycle its last operand is broadcast.
  - If it issues, the entry still frees normally.
- Undefined: wakeup is registered only; issue happens at the earliest one cycle after the broadcast.

Test Plan:
1. Reset mid-operation:
   - stimulus: fill 2 entries, then assert rst asynchronously between edges.
   - response: immediately ready=1, index=0, issue_valid=0; the next dispatch lands in slot 0.
2. Oldest-first selection:
   - stimulus: dispatch A to slot 0 waiting on tag 5, then B to slot 1 ready; then broadcast tag 5 = 0x1234.
   - response: B issues first. A issues the cycle after the broadcast with operand[0]=0x1234 (same cycle if RS_CDB_BYPASS_EN).
3. Full boundary:
   - stimulus: dispatch 4 non-ready entries.
   - response: ready=0 after the 4th edge. Ack the issue of slot 2: ready=1, index=2 only on the following cycle.
4. Dispatch/CDB collision:
   - stimulus: taken with operand_addr[1]=7 not ready, while cdb_valid[1]=1 with tag 7 and data 0xDEAD.
   - response: next cycle issue_valid=1 with operand[1]=0xDEAD.
5. Flush priority:
   - stimulus: flush, taken, issue_ack and a CDB hit all in the same cycle with 3 entries busy.
   - response: next cycle no entry busy, ready=1, index=0, issue_valid=0.
6. Backpressure:
   - stimulus: issue_valid=1 with issue_ack=0 for 3 cycles, no new ready entries.
   - response: issue_entry is identical across all cycles; no entry is lost or duplicated after the ack.
